// File: rtl/user_irq_pkg.sv
// Shared constants and types for the user_irq_gen interrupt source block:
// register offsets, TCTRL bit positions, IRQ line indices and timer states.
package user_irq_pkg;

  localparam logic [7:0] REG_ENABLE  = 8'h00;
  localparam logic [7:0] REG_PENDING = 8'h04;
  localparam logic [7:0] REG_FORCE   = 8'h08;
  localparam logic [7:0] REG_LOAD    = 8'h0C;
  localparam logic [7:0] REG_TCTRL   = 8'h10;
  localparam logic [7:0] REG_COUNT   = 8'h14;

  localparam int TCTRL_RUN      = 0;
  localparam int TCTRL_PERIODIC = 1;

  localparam int IRQ_EXT0  = 0;
  localparam int IRQ_EXT1  = 1;
  localparam int IRQ_TIMER = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } timer_state_t;

  // Word-aligned register offset within the 256-byte window.
  function automatic logic [7:0] reg_offset(input logic [31:0] adr);
    return {adr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Synchronises one asynchronous pin and emits a single-cycle pulse on each
// synchronised 0->1 transition.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   armed;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // fill tracks when the chain holds real pin samples; armed requires the
  // pin to be seen low first, so a pin held high through reset cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], pin};
      fill  <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev  <= synced;
      armed <= armed | (fill[SYNC_STAGES-1] & ~synced);
    end
  end

  assign rise = synced & ~prev & armed;

endmodule

// File: rtl/user_irq_gen.sv
// Wishbone-programmable interrupt source: two external pin edges, a down
// counting timer and software force, each masked onto one user_irq line.
module user_irq_gen
  import user_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          TIMER_W     = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic [1:0]  ext_in,
  output logic [2:0]  user_irq
);

  logic               select;
  logic               wr;
  logic [7:0]         offset;
  logic               wr_enable;
  logic               wr_pending;
  logic               wr_force;
  logic               wr_load;
  logic               wr_tctrl;
  logic [2:0]         enable;
  logic [2:0]         pending;
  logic [2:0]         hw_set;
  logic [2:0]         force_set;
  logic [2:0]         clr_set;
  logic [TIMER_W-1:0] load;
  logic [TIMER_W-1:0] count;
  logic [31:0]        byte_mask;
  logic               periodic;
  logic [1:0]         rise;
  logic [31:0]        rd_data;
  timer_state_t       state;
  timer_state_t       state_next;
  logic               run_req;
  logic               start;
  logic               stop;
  logic               expire;
  logic               dec;

  assign select = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
  assign wr     = select & wbs_we_i;
  assign offset = reg_offset(wbs_adr_i);

  irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .pin  (ext_in[0]),
    .rise (rise[0])
  );

  irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .pin  (ext_in[1]),
    .rise (rise[1])
  );

  always_comb begin
    wr_enable  = 1'b0;
    wr_pending = 1'b0;
    wr_force   = 1'b0;
    wr_load    = 1'b0;
    wr_tctrl   = 1'b0;
    case (offset)
      REG_ENABLE:  wr_enable  = wr & wbs_sel_i[0];
      REG_PENDING: wr_pending = wr & wbs_sel_i[0];
      REG_FORCE:   wr_force   = wr & wbs_sel_i[0];
      REG_LOAD:    wr_load    = wr;
      REG_TCTRL:   wr_tctrl   = wr & wbs_sel_i[0];
      default:     wr_enable  = 1'b0;
    endcase
  end

  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign force_set = wr_force   ? wbs_dat_i[2:0] : 3'b000;
  assign clr_set   = wr_pending ? wbs_dat_i[2:0] : 3'b000;
  assign run_req   = wbs_dat_i[TCTRL_RUN];

  always_comb begin
    hw_set            = 3'b000;
    hw_set[IRQ_EXT0]  = rise[0];
    hw_set[IRQ_EXT1]  = rise[1];
    hw_set[IRQ_TIMER] = expire;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A RUN=0 write takes priority over a one-shot expiry in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (wr_tctrl && run_req) state_next = COUNTING;
        else                     state_next = IDLE;
      end
      COUNTING: begin
        if (wr_tctrl && !run_req)            state_next = IDLE;
        else if ((count == '0) && !periodic) state_next = IDLE;
        else                                 state_next = COUNTING;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    stop   = 1'b0;
    expire = 1'b0;
    dec    = 1'b0;
    case (state)
      IDLE: begin
        start = wr_tctrl & run_req;
      end
      COUNTING: begin
        stop   = wr_tctrl & ~run_req;
        expire = ~stop & (count == '0);
        dec    = ~stop & (count != '0);
      end
      default: start = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count <= '0;
    end else if (start || (expire && periodic)) begin
      count <= load;
    end else if (dec) begin
      count <= count - TIMER_W'(1);
    end else begin
      count <= count;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enable   <= 3'b000;
      pending  <= 3'b000;
      load     <= '0;
      periodic <= 1'b0;
      user_irq <= 3'b000;
    end else begin
      if (wr_enable) enable <= wbs_dat_i[2:0];
      if (wr_load)   load   <= (load & ~byte_mask[TIMER_W-1:0]) | (wbs_dat_i[TIMER_W-1:0] & byte_mask[TIMER_W-1:0]);
      if (wr_tctrl)  periodic <= wbs_dat_i[TCTRL_PERIODIC];
      // Sets are OR-ed after the clear so a coincident event is never lost.
      pending  <= (pending & ~clr_set) | hw_set | force_set;
      user_irq <= pending & enable;
    end
  end

  always_comb begin
    rd_data = 32'h0000_0000;
    case (offset)
      REG_ENABLE:  rd_data[2:0] = enable;
      REG_PENDING: rd_data[2:0] = pending;
      REG_LOAD:    rd_data[TIMER_W-1:0] = load;
      REG_TCTRL: begin
        rd_data[TCTRL_RUN]      = (state == COUNTING);
        rd_data[TCTRL_PERIODIC] = periodic;
      end
      REG_COUNT:   rd_data[TIMER_W-1:0] = count;
      default:     rd_data = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0000_0000;
    end else begin
      wbs_ack_o <= select;
      wbs_dat_o <= (select && !wbs_we_i) ? rd_data : 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_user_irq_gen.sv
// Scoreboard bench for user_irq_gen: bus tasks queue the expected read data,
// a negedge monitor pops and compares on every ack.
module tb_user_irq_gen;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] dat_w = 32'h0;
  logic        ack;
  logic [31:0] dat_r;
  logic [1:0]  ext = 2'b00;
  logic [2:0]  irq;

  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  logic        ack_prev = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  user_irq_gen dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .ext_in    (ext),
    .user_irq  (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_irq(input string name, input logic [2:0] exp);
    check(name, {29'h0, irq}, {29'h0, exp});
  endtask

  // Monitor: every ack must be single-cycle and match the queued expectation.
  always @(negedge clk) begin
    if (ack) begin
      check("ack_single", {31'h0, ack_prev}, 32'h0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: ack with nothing outstanding, dat_o=%h at %0t", dat_r, $time);
      end else begin
        exp_word = exp_q.pop_front();
        check("rd_data", dat_r, exp_word);
      end
    end
    ack_prev = ack;
  end

  task automatic wb(input logic w, input logic [7:0] off, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s;
    adr = BASE | {24'h0, off}; dat_w = d;
    exp_q.push_back(w ? 32'h0 : exp);
    @(posedge clk); #1;
    check("ack_latency", {31'h0, ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    wb(1'b1, off, d, 4'hF, 32'h0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp);
    wb(1'b0, off, 32'h0, 4'hF, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();

    // 1: reset values
    check_irq("reset_irq", 3'b000);
    for (int i = 0; i < 6; i++) rd(8'(i * 4), 32'h0);

    // 2: ext_in[0] edge, latency, W1C
    wr(8'h00, 32'h3);
    ext[0] = 1'b1;
    repeat (3) tick();
    check_irq("ext0_not_yet", 3'b000);
    tick();
    check_irq("ext0_irq", 3'b001);
    tick();
    ext[0] = 1'b0;
    rd(8'h04, 32'h1);
    wr(8'h04, 32'h1);
    check_irq("w1c_hold", 3'b001);
    tick();
    check_irq("w1c_clear", 3'b000);

    // 3: one-shot timer, LOAD=9
    wr(8'h00, 32'h4);
    wr(8'h0C, 32'd9);
    wr(8'h10, 32'h1);
    repeat (10) tick();
    check_irq("oneshot_before", 3'b000);
    tick();
    check_irq("oneshot_fire", 3'b100);
    rd(8'h10, 32'h0);
    rd(8'h14, 32'h0);
    rd(8'h04, 32'h4);
    wr(8'h04, 32'h4);

    // 4: periodic timer, LOAD=4 -> period 5
    wr(8'h0C, 32'd4);
    wr(8'h10, 32'h3);
    repeat (5) tick();
    check_irq("periodic_before", 3'b000);
    tick();
    check_irq("periodic_fire0", 3'b100);
    for (int k = 0; k < 3; k++) begin
      wr(8'h04, 32'h4);
      tick();
      check_irq("periodic_gap_a", 3'b000);
      tick();
      check_irq("periodic_gap_b", 3'b000);
      tick();
      check_irq("periodic_refire", 3'b100);
    end
    wr(8'h10, 32'h2);
    rd(8'h14, 32'd2);
    rd(8'h10, 32'h2);
    wr(8'h04, 32'h4);
    repeat (10) tick();
    rd(8'h04, 32'h0);
    rd(8'h14, 32'd2);

    // 5: ext_in[1] edge coincident with W1C of bit1, then FORCE while masked
    ext[1] = 1'b1;
    tick();
    wr(8'h04, 32'h2);
    rd(8'h04, 32'h2);
    ext[1] = 1'b0;
    wr(8'h00, 32'h0);
    wr(8'h04, 32'h2);
    wr(8'h08, 32'h2);
    rd(8'h04, 32'h2);
    rd(8'h08, 32'h0);
    check_irq("force_masked", 3'b000);
    wr(8'h04, 32'h7);

    // 6: foreign address, byte select, unmapped offset, reset mid-run
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0100;
    tick();
    check("foreign_noack_a", {31'h0, ack}, 32'h0);
    tick();
    check("foreign_noack_b", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    wb(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'b0001, 32'h0);
    rd(8'h0C, 32'h0000_00FF);
    wr(8'h18, 32'hFFFF_FFFF);
    rd(8'h18, 32'h0);
    wr(8'h00, 32'h4);
    wr(8'h10, 32'h1);
    wr(8'h08, 32'h4);
    tick();
    check_irq("pre_reset_irq", 3'b100);
    tick();
    rst = 1'b1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
    tick();
    check("reset_noack", {31'h0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tick();
    rst = 1'b0;
    check_irq("post_reset_irq", 3'b000);
    rd(8'h14, 32'h0);
    rd(8'h10, 32'h0);
    rd(8'h0C, 32'h0);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
